// File: rtl/cic_decimator_multistage.sv
// Multistage CIC decimator: pipelined integrators, decimated combs,
// round-half-up shift by N*log2(R), saturation and warm-up suppression.
module cic_decimator_multistage #(
  parameter int INPUT_WIDTH    = 16,
  parameter int N_STAGES       = 3,
  parameter int LOG2_MAX_DECIM = 6
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      clear,
  input  logic [$clog2(LOG2_MAX_DECIM+1)-1:0]       log2_decim,
  input  logic signed [INPUT_WIDTH-1:0]             din,
  input  logic                                      din_valid,
  output logic signed [INPUT_WIDTH-1:0]             dout,
  output logic                                      dout_valid
);

  localparam int IW = INPUT_WIDTH + N_STAGES * LOG2_MAX_DECIM;
  localparam int LW = $clog2(LOG2_MAX_DECIM + 1);
  localparam int CW = LOG2_MAX_DECIM;
  localparam int SW = $clog2(N_STAGES * LOG2_MAX_DECIM + 1);
  localparam int WW = $clog2(N_STAGES + 1);
  localparam logic signed [IW:0] SMAX = (IW+1)'(2**(INPUT_WIDTH-1) - 1);
  localparam logic signed [IW:0] SMIN = -(IW+1)'(2**(INPUT_WIDTH-1));

  logic [LW-1:0] rate_req;
  logic [LW-1:0] rate_q;
  logic          flush;
  logic [CW:0]   one_hot;
  logic [CW-1:0] mask;
  logic [CW-1:0] cnt;
  logic          last;
  logic [SW-1:0] shamt;
  logic signed [IW:0] half;

  logic signed [IW-1:0] integ [N_STAGES];
  logic [N_STAGES-1:0]  iv;
  logic [N_STAGES-1:0]  im;

  logic signed [IW-1:0] comb [N_STAGES];
  logic signed [IW-1:0] dly  [N_STAGES];
  logic [N_STAGES-1:0]  cv;

  logic signed [IW:0]   comb_ext;
  logic signed [IW:0]   rnd;
  logic signed [IW:0]   shf;
  logic                 rv;
  logic                 sv;
  logic [WW-1:0]        wu;
  logic signed [INPUT_WIDTH-1:0] sat_val;

  assign rate_req = (log2_decim > LW'(LOG2_MAX_DECIM)) ?
                    LW'(LOG2_MAX_DECIM) : log2_decim;
  assign flush    = clear | (rate_req != rate_q);
  assign one_hot  = (CW+1)'(1) << rate_q;
  assign mask     = one_hot[CW-1:0] - CW'(1);
  assign last     = (cnt == mask);
  assign shamt    = SW'(N_STAGES) * SW'(rate_q);
  assign half     = (shamt == '0) ? '0 : ((IW+1)'(1) << (shamt - SW'(1)));
  assign comb_ext = {comb[N_STAGES-1][IW-1], comb[N_STAGES-1]};

  always_comb begin
    sat_val = INPUT_WIDTH'(shf);
    if (shf > SMAX)      sat_val = INPUT_WIDTH'(SMAX);
    else if (shf < SMIN) sat_val = INPUT_WIDTH'(SMIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rate_q <= '0;
    else        rate_q <= rate_req;
  end

  // Integrator tokens carry the decimation mark down to the comb section.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      iv  <= '0;
      im  <= '0;
      for (int k = 0; k < N_STAGES; k++) integ[k] <= '0;
    end else if (flush) begin
      cnt <= '0;
      iv  <= '0;
      im  <= '0;
      for (int k = 0; k < N_STAGES; k++) integ[k] <= '0;
    end else begin
      iv[0] <= din_valid;
      im[0] <= din_valid & last;
      if (din_valid) begin
        integ[0] <= integ[0] + IW'(din);
        cnt      <= last ? '0 : cnt + CW'(1);
      end
      for (int k = 1; k < N_STAGES; k++) begin
        iv[k] <= iv[k-1];
        im[k] <= im[k-1] & iv[k-1];
        if (iv[k-1]) integ[k] <= integ[k] + integ[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cv <= '0;
      for (int k = 0; k < N_STAGES; k++) begin
        comb[k] <= '0;
        dly[k]  <= '0;
      end
    end else if (flush) begin
      cv <= '0;
      for (int k = 0; k < N_STAGES; k++) begin
        comb[k] <= '0;
        dly[k]  <= '0;
      end
    end else begin
      cv[0] <= iv[N_STAGES-1] & im[N_STAGES-1];
      if (iv[N_STAGES-1] & im[N_STAGES-1]) begin
        comb[0] <= integ[N_STAGES-1] - dly[0];
        dly[0]  <= integ[N_STAGES-1];
      end
      for (int k = 1; k < N_STAGES; k++) begin
        cv[k] <= cv[k-1];
        if (cv[k-1]) begin
          comb[k] <= comb[k-1] - dly[k];
          dly[k]  <= comb[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv         <= 1'b0;
      sv         <= 1'b0;
      rnd        <= '0;
      shf        <= '0;
      wu         <= WW'(N_STAGES);
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (flush) begin
      rv         <= 1'b0;
      sv         <= 1'b0;
      rnd        <= '0;
      shf        <= '0;
      wu         <= WW'(N_STAGES);
      dout_valid <= 1'b0;
    end else begin
      rv         <= cv[N_STAGES-1];
      sv         <= rv;
      dout_valid <= sv && (wu == '0);
      if (cv[N_STAGES-1]) rnd <= comb_ext + half;
      if (rv)             shf <= rnd >>> shamt;
      if (sv) begin
        if (wu != '0) wu   <= wu - WW'(1);
        else          dout <= sat_val;
      end
    end
  end

endmodule

// File: tb/tb_cic_decimator_multistage.sv
// Bench for cic_decimator_multistage: directed phases with random data,
// checked against a convolution model of the CIC impulse response.
module tb_cic_decimator_multistage;

  localparam int W   = 16;
  localparam int N   = 3;
  localparam int LMD = 6;
  localparam int LAT = 2 * N + 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                clear = 1'b0;
  logic [2:0]          log2_decim = '0;
  logic signed [W-1:0] din = '0;
  logic                din_valid = 1'b0;
  logic signed [W-1:0] dout;
  logic                dout_valid;

  cic_decimator_multistage #(
    .INPUT_WIDTH(W), .N_STAGES(N), .LOG2_MAX_DECIM(LMD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .log2_decim(log2_decim), .din(din), .din_valid(din_valid),
    .dout(dout), .dout_valid(dout_valid)
  );

  always #5 clk = ~clk;

  typedef struct { longint t; longint v; } exp_t;

  int     tests = 0;
  int     fails = 0;
  longint cyc = 0;
  exp_t   q[$];
  longint hist[$];
  int     m_rate = 0;
  int     n_acc = 0;
  longint m_dout = 0;
  longint h [0:511];
  int     hlen = 1;

  task automatic chk(string tag, logic signed [63:0] obs,
                     logic signed [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)",
             tag, obs, expv, cyc);
    end
  endtask

  function automatic int clamp(int v);
    return (v > LMD) ? LMD : v;
  endfunction

  // Impulse response = boxcar of length R convolved with itself N times.
  function automatic void build_h(int r);
    longint nh [0:511];
    int rr = 1 << r;
    for (int i = 0; i < 512; i++) h[i] = 0;
    h[0] = 1;
    hlen = 1;
    repeat (N) begin
      for (int i = 0; i < 512; i++) nh[i] = 0;
      for (int i = 0; i < hlen + rr - 1; i++)
        for (int j = 0; j < rr; j++)
          if (i - j >= 0 && i - j < hlen) nh[i] += h[i-j];
      hlen = hlen + rr - 1;
      for (int i = 0; i < 512; i++) h[i] = nh[i];
    end
  endfunction

  function automatic longint out_val();
    longint y = 0;
    longint v;
    int s = N * m_rate;
    for (int k = 0; k < hlen; k++)
      if (hist.size() - 1 - k >= 0) y += h[k] * hist[hist.size()-1-k];
    if (s > 0) y += (64'sd1 <<< (s - 1));
    v = y >>> s;
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  function automatic void model_reset();
    q.delete();
    hist.delete();
    n_acc  = 0;
    m_rate = 0;
    m_dout = 0;
    build_h(0);
  endfunction

  function automatic void model_edge();
    int rq = clamp(int'(log2_decim));
    int rr;
    if (clear || rq != m_rate) begin
      q.delete();
      hist.delete();
      n_acc  = 0;
      m_rate = rq;
      build_h(rq);
    end else if (din_valid) begin
      rr = 1 << m_rate;
      hist.push_back(longint'(din));
      if (hist.size() > 400) void'(hist.pop_front());
      n_acc++;
      if (n_acc % rr == 0 && n_acc / rr - 1 >= N)
        q.push_back('{t: cyc + LAT, v: out_val()});
    end
  endfunction

  task automatic tick();
    exp_t e;
    logic ev;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    ev = (q.size() > 0) && (q[0].t == cyc);
    chk("dout_valid", 64'(dout_valid), 64'(ev));
    if (ev) begin
      e = q.pop_front();
      chk("dout_strobe", 64'(dout), e.v);
      m_dout = e.v;
    end else begin
      chk("dout_held", 64'(dout), m_dout);
    end
  endtask

  task automatic run(int cycles, int dc, int mode);
    for (int i = 0; i < cycles; i++) begin
      case (mode)
        0: din_valid = 1'b1;
        1: din_valid = (i % 2 == 0);
        default: din_valid = 1'($urandom);
      endcase
      din = (dc == 99999) ? W'($urandom) : W'(dc);
      tick();
    end
  endtask

  initial begin
    build_h(0);
    #2;
    chk("reset_dout", 64'(dout), 0);
    chk("reset_valid", 64'(dout_valid), 0);
    repeat (2) begin @(posedge clk); cyc++; end
    #2 rst_n = 1'b1;
    model_reset();

    // DC 1000 at R=4
    log2_decim = 3'd2;
    run(4, 0, 2);
    din_valid = 1'b0;
    tick();
    run(4 * 20, 1000, 0);

    // Full-scale DC at R=64, both polarities
    log2_decim = 3'd6;
    run(64 * 7, 32767, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    run(64 * 7, -32768, 0);

    // Gapped input at R=8
    log2_decim = 3'd3;
    run(16 * 10, -500, 1);

    // Rate change 2 -> 5 mid-stream
    log2_decim = 3'd2;
    run(4 * 24, 300, 0);
    log2_decim = 3'd5;
    run(32 * 8, 300, 0);

    // Wrapping integrators, then asynchronous reset mid-frame
    log2_decim = 3'd3;
    run(4000, 20000, 0);
    run(3, 20000, 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_dout", 64'(dout), 0);
    chk("async_rst_valid", 64'(dout_valid), 0);
    model_reset();
    repeat (2) begin @(posedge clk); cyc++; end
    #2 rst_n = 1'b1;
    run(8 * 8, 20000, 0);

    // R=1 passthrough with random data
    log2_decim = 3'd0;
    run(300, 99999, 0);

    // Random data and valid at R=8, clear together with valid
    log2_decim = 3'd3;
    run(1000, 99999, 2);
    clear = 1'b1;
    din_valid = 1'b1;
    din = 16'sd12345;
    tick();
    clear = 1'b0;
    run(800, 99999, 2);

    // Out-of-range rate clamps to the maximum
    log2_decim = 3'd7;
    run(64 * 6, 99999, 0);
    log2_decim = 3'd6;
    run(64 * 2, 99999, 0);

    din_valid = 1'b0;
    repeat (30) tick();
    chk("queue_drained", 64'(q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
